mcs_di_bridge: RTL and testbench

MCS_DI_BRIDGE -- requirements
Module: mcs_di_bridge

---
 rtl/mcs_di_bridge_if.sv | 34 +++
 rtl/mcs_di_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_mcs_di_bridge.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcs_di_bridge_if.sv
// MicroBlaze MCS IO bus bundle: the MCS drives strobes/address/data,
// the bridge answers with read data and ready.
interface mcs_di_bridge_if;
    logic        IO_Addr_Strobe;
    logic        IO_Read_Strobe;
    logic        IO_Write_Strobe;
    logic [31:0] IO_Address;
    logic [3:0]  IO_Byte_Enable;
    logic [31:0] IO_Write_Data;
    logic [31:0] IO_Read_Data;
    logic        IO_Ready;

    modport master (
        output IO_Addr_Strobe,
        output IO_Read_Strobe,
        output IO_Write_Strobe,
        output IO_Address,
        output IO_Byte_Enable,
        output IO_Write_Data,
        input  IO_Read_Data,
        input  IO_Ready
    );

    modport slave (
        input  IO_Addr_Strobe,
        input  IO_Read_Strobe,
        input  IO_Write_Strobe,
        input  IO_Address,
        input  IO_Byte_Enable,
        input  IO_Write_Data,
        output IO_Read_Data,
        output IO_Ready
    );
endinterface

// File: rtl/mcs_di_bridge.sv
// Bridges single MicroBlaze MCS IO bus accesses onto the DI register
// interface, with byte-lane alignment and a bounded wait for DI ready.
module mcs_di_bridge #(
    parameter int unsigned TERM_WIDTH     = 16,
    parameter int unsigned TIMEOUT        = 1023,
    parameter int unsigned CNT_WIDTH      = 10,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
    parameter logic [15:0] TIMEOUT_STATUS = 16'hFFFF
) (
    input  logic                  ifclk,
    input  logic                  reset,

    mcs_di_bridge_if.slave        io,

    input  logic [TERM_WIDTH-1:0] mcs_term_addr,
    output logic [15:0]           mcs_transfer_status,
    input  logic                  timeout_clr,
    output logic                  timeout_err,
    output logic                  busy,

    output logic [TERM_WIDTH-1:0] di_term_addr,
    output logic [31:0]           di_reg_addr,
    output logic [31:0]           di_len,
    output logic                  di_read_mode,
    output logic                  di_read_req,
    output logic                  di_read,
    input  logic                  di_read_rdy,
    input  logic [31:0]           di_reg_datao,
    output logic                  di_write_mode,
    output logic                  di_write,
    input  logic                  di_write_rdy,
    output logic [31:0]           di_reg_datai,
    input  logic [15:0]           di_transfer_status
);

    localparam int unsigned     ADDR_W  = 28;
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nx;

    logic [ADDR_W-1:0]     addr_q;
    logic [3:0]            be_q;
    logic [31:0]           data_q;
    logic [TERM_WIDTH-1:0] term_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [31:0]           rd_data_q;
    logic [15:0]           status_q;
    logic                  timeout_err_q;

    logic                  accept_rd;
    logic                  accept_wr;
    logic                  wait_st;
    logic                  rdy_c;
    logic                  timeout_hit;
    logic [1:0]            lane;
    logic [4:0]            lane_sh;
    logic [31:0]           be_mask;

    logic                  ready_c;
    logic                  busy_c;
    logic                  rd_mode_c;
    logic                  rd_req_c;
    logic                  rd_pulse_c;
    logic                  wr_mode_c;
    logic                  wr_pulse_c;

    // Only word address bits 29:2 reach the DI side.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{io.IO_Address[31:30], io.IO_Address[1:0]};

    function automatic logic [1:0] lane_of(input logic [3:0] be);
        if (be[0])      return 2'd0;
        else if (be[1]) return 2'd1;
        else if (be[2]) return 2'd2;
        else if (be[3]) return 2'd3;
        else            return 2'd0;
    endfunction

    assign accept_rd = (state == IDLE) && io.IO_Addr_Strobe && io.IO_Read_Strobe;
    assign accept_wr = (state == IDLE) && io.IO_Addr_Strobe && io.IO_Write_Strobe
                       && !io.IO_Read_Strobe;

    assign wait_st     = (state == RD_WAIT) || (state == WR_WAIT);
    assign rdy_c       = (state == RD_WAIT) ? di_read_rdy : di_write_rdy;
    assign timeout_hit = TO_EN && wait_st && !rdy_c && (cnt_q == TO_LAST);

    // State register.
    always_ff @(posedge ifclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a read strobe takes priority over a write strobe.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_rd)      state_nx = RD_REQ;
                else if (accept_wr) state_nx = WR_WAIT;
            end
            RD_REQ:  state_nx = RD_WAIT;
            RD_WAIT: if (di_read_rdy || timeout_hit)  state_nx = RESP;
            WR_WAIT: if (di_write_rdy || timeout_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State decode; everything is forced low while reset is held.
    always_comb begin
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        rd_mode_c  = 1'b0;
        rd_req_c   = 1'b0;
        rd_pulse_c = 1'b0;
        wr_mode_c  = 1'b0;
        wr_pulse_c = 1'b0;
        if (!reset) begin
            busy_c = (state != IDLE);
            case (state)
                RD_REQ: begin
                    rd_mode_c = 1'b1;
                    rd_req_c  = 1'b1;
                end
                RD_WAIT: begin
                    rd_mode_c  = 1'b1;
                    rd_pulse_c = di_read_rdy;
                end
                WR_WAIT: begin
                    wr_mode_c  = 1'b1;
                    wr_pulse_c = di_write_rdy;
                end
                RESP:    ready_c = 1'b1;
                default: ;
            endcase
        end
    end

    // Request capture, held stable for the whole transaction.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            addr_q <= '0;
            be_q   <= '0;
            data_q <= '0;
            term_q <= '0;
        end else begin
            if (accept_rd || accept_wr) begin
                addr_q <= io.IO_Address[29:2];
                be_q   <= io.IO_Byte_Enable;
                term_q <= mcs_term_addr;
            end
            if (accept_wr) data_q <= io.IO_Write_Data;
        end
    end

    assign lane    = lane_of(be_q);
    assign lane_sh = {lane, 3'b000};
    assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    always_comb begin
        case (be_q)
            4'hF:       di_len = 32'd4;
            4'h3, 4'hC: di_len = 32'd2;
            default:    di_len = 32'd1;
        endcase
    end

    // Wait counter: cleared on entering a wait state, saturates at all ones.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (((state_nx == RD_WAIT) || (state_nx == WR_WAIT)) && !wait_st) begin
            cnt_q <= '0;
        end else if (wait_st && !rdy_c && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // Response capture; a real DI completion always beats the timeout.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            rd_data_q <= '0;
            status_q  <= '0;
        end else if (rd_pulse_c) begin
            rd_data_q <= (di_reg_datao << lane_sh) & be_mask;
            status_q  <= di_transfer_status;
        end else if (wr_pulse_c) begin
            status_q  <= di_transfer_status;
        end else if (timeout_hit) begin
            rd_data_q <= ERR_DATA;
            status_q  <= TIMEOUT_STATUS;
        end
    end

    // Sticky timeout flag; a new timeout wins over a simultaneous clear.
    always_ff @(posedge ifclk) begin
        if (reset)            timeout_err_q <= 1'b0;
        else if (timeout_hit) timeout_err_q <= 1'b1;
        else if (timeout_clr) timeout_err_q <= 1'b0;
    end

    assign io.IO_Ready          = ready_c;
    assign io.IO_Read_Data      = rd_data_q;
    assign mcs_transfer_status  = status_q;
    assign timeout_err          = timeout_err_q;
    assign busy                 = busy_c;

    assign di_term_addr  = term_q;
    assign di_reg_addr   = {4'b0000, addr_q};
    assign di_reg_datai  = data_q >> lane_sh;
    assign di_read_mode  = rd_mode_c;
    assign di_read_req   = rd_req_c;
    assign di_read       = rd_pulse_c;
    assign di_write_mode = wr_mode_c;
    assign di_write      = wr_pulse_c;

endmodule

// File: tb/tb_mcs_di_bridge.sv
// Directed scoreboard bench for mcs_di_bridge (TIMEOUT reduced to 8).
module tb_mcs_di_bridge;

    logic        ifclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mcs_term_addr = '0;
    logic [15:0] mcs_transfer_status;
    logic        timeout_clr = 1'b0;
    logic        timeout_err;
    logic        busy;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_read;
    logic        di_read_rdy = 1'b0;
    logic [31:0] di_reg_datao = '0;
    logic        di_write_mode;
    logic        di_write;
    logic        di_write_rdy = 1'b0;
    logic [31:0] di_reg_datai;
    logic [15:0] di_transfer_status = '0;

    mcs_di_bridge_if io();

    mcs_di_bridge #(.TIMEOUT(8)) dut (
        .ifclk               (ifclk),
        .reset               (reset),
        .io                  (io),
        .mcs_term_addr       (mcs_term_addr),
        .mcs_transfer_status (mcs_transfer_status),
        .timeout_clr         (timeout_clr),
        .timeout_err         (timeout_err),
        .busy                (busy),
        .di_term_addr        (di_term_addr),
        .di_reg_addr         (di_reg_addr),
        .di_len              (di_len),
        .di_read_mode        (di_read_mode),
        .di_read_req         (di_read_req),
        .di_read             (di_read),
        .di_read_rdy         (di_read_rdy),
        .di_reg_datao        (di_reg_datao),
        .di_write_mode       (di_write_mode),
        .di_write            (di_write),
        .di_write_rdy        (di_write_rdy),
        .di_reg_datai        (di_reg_datai),
        .di_transfer_status  (di_transfer_status)
    );

    always #5 ifclk = ~ifclk;

    typedef struct {
        bit          chk_data;
        logic [31:0] data;
        logic [15:0] status;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rd_pulses = 0;
    int   wr_pulses = 0;
    int   both_cnt  = 0;
    int   rdy_cnt   = 0;

    always @(negedge ifclk) begin
        if (di_read === 1'b1)  rd_pulses++;
        if (di_write === 1'b1) wr_pulses++;
        if (di_read === 1'b1 && di_write === 1'b1) both_cnt++;
        if (io.IO_Ready === 1'b1) rdy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Called just after a rising edge; strobes for one cycle, then scrambles the bus.
    task automatic start(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        io.IO_Addr_Strobe  = 1'b1;
        io.IO_Read_Strobe  = rd;
        io.IO_Write_Strobe = wr;
        io.IO_Address      = addr;
        io.IO_Byte_Enable  = be;
        io.IO_Write_Data   = wd;
        @(posedge ifclk); #2;
        io.IO_Addr_Strobe  = 1'b0;
        io.IO_Read_Strobe  = 1'b0;
        io.IO_Write_Strobe = 1'b0;
        io.IO_Address      = ~addr;
        io.IO_Byte_Enable  = ~be;
        io.IO_Write_Data   = ~wd;
        mcs_term_addr      = ~mcs_term_addr;
    endtask

    // Waits (bounded) for IO_Ready, checks latency and the scoreboard entry.
    task automatic finish_txn(input string tag, input int start_cyc, input int exp_lat);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = start_cyc;
        seen = 1'b0;
        while (cyc <= 40) begin
            @(negedge ifclk);
            if (io.IO_Ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge ifclk); #2;
            cyc++;
        end
        check({tag, " ready_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            if (e.chk_data) check({tag, " rd_data"}, io.IO_Read_Data, e.data);
            check({tag, " status"}, 32'(mcs_transfer_status), 32'(e.status));
        end
        @(posedge ifclk); #2;
        @(negedge ifclk);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_ready"}, 32'(io.IO_Ready), 32'd0);
        @(posedge ifclk); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rp, wp, rc;
        io.IO_Addr_Strobe  = 1'b0;
        io.IO_Read_Strobe  = 1'b0;
        io.IO_Write_Strobe = 1'b0;
        io.IO_Address      = '0;
        io.IO_Byte_Enable  = '0;
        io.IO_Write_Data   = '0;

        // Reset state
        repeat (3) @(posedge ifclk);
        #2 reset = 1'b0;
        @(negedge ifclk);
        check("rst ready", 32'(io.IO_Ready), 32'd0);
        check("rst rd_data", io.IO_Read_Data, 32'd0);
        check("rst status", 32'(mcs_transfer_status), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst terr", 32'(timeout_err), 32'd0);
        check("rst di_len", di_len, 32'd1);
        check("rst rd_mode", 32'(di_read_mode), 32'd0);
        @(posedge ifclk); #2;

        // Read BE=F, rdy already high
        di_read_rdy = 1'b1; di_reg_datao = 32'h12345678; di_transfer_status = 16'h1234;
        mcs_term_addr = 16'hBEEF;
        sb.push_back('{1'b1, 32'h12345678, 16'h1234});
        rp = rd_pulses; wp = wr_pulses;
        start(1'b1, 1'b0, 32'hC000_0010, 4'hF, 32'h0);
        @(negedge ifclk);
        check("rdf req", 32'(di_read_req), 32'd1);
        check("rdf mode", 32'(di_read_mode), 32'd1);
        check("rdf reg_addr", di_reg_addr, 32'd4);
        check("rdf len", di_len, 32'd4);
        check("rdf term", 32'(di_term_addr), 32'hBEEF);
        check("rdf busy", 32'(busy), 32'd1);
        @(posedge ifclk); #2;
        finish_txn("rdf", 2, 3);
        check("rdf rd_pulses", 32'(rd_pulses - rp), 32'd1);
        check("rdf wr_pulses", 32'(wr_pulses - wp), 32'd0);

        // Write BE=C, rdy low for 5 wait cycles
        di_read_rdy = 1'b0; di_write_rdy = 1'b0; di_transfer_status = 16'h5A5A;
        sb.push_back('{1'b0, 32'h0, 16'h5A5A});
        rp = rd_pulses; wp = wr_pulses;
        start(1'b0, 1'b1, 32'h0000_0020, 4'hC, 32'hABCD_0000);
        @(negedge ifclk);
        check("wrc len", di_len, 32'd2);
        check("wrc datai", di_reg_datai, 32'h0000_ABCD);
        check("wrc reg_addr", di_reg_addr, 32'd8);
        check("wrc mode", 32'(di_write_mode), 32'd1);
        check("wrc no_write_yet", 32'(di_write), 32'd0);
        repeat (5) @(posedge ifclk);
        #2 di_write_rdy = 1'b1;
        finish_txn("wrc", 6, 7);
        di_write_rdy = 1'b0;
        check("wrc wr_pulses", 32'(wr_pulses - wp), 32'd1);
        check("wrc rd_pulses", 32'(rd_pulses - rp), 32'd0);

        // Read BE=4, single byte lane 2
        di_read_rdy = 1'b1; di_reg_datao = 32'h0000_00EE; di_transfer_status = 16'h0001;
        sb.push_back('{1'b1, 32'h00EE_0000, 16'h0001});
        start(1'b1, 1'b0, 32'h0000_0010, 4'h4, 32'h0);
        @(negedge ifclk);
        check("rdb4 len", di_len, 32'd1);
        @(posedge ifclk); #2;
        finish_txn("rdb4", 2, 3);

        // Read timeout; clear in the timeout cycle loses to the set
        di_read_rdy = 1'b0; di_transfer_status = 16'h0123;
        sb.push_back('{1'b1, 32'hDEAD_BEEF, 16'hFFFF});
        rp = rd_pulses;
        start(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
        repeat (8) @(posedge ifclk);
        #2 timeout_clr = 1'b1;
        @(posedge ifclk);
        #2 timeout_clr = 1'b0;
        finish_txn("tmo", 10, 10);
        check("tmo rd_pulses", 32'(rd_pulses - rp), 32'd0);
        check("tmo terr_sticky", 32'(timeout_err), 32'd1);
        check("tmo rd_data_held", io.IO_Read_Data, 32'hDEAD_BEEF);
        timeout_clr = 1'b1;
        @(posedge ifclk);
        #2 timeout_clr = 1'b0;
        @(negedge ifclk);
        check("tmo terr_clr", 32'(timeout_err), 32'd0);
        @(posedge ifclk); #2;

        // rdy arrives exactly in the timeout cycle: completes normally
        di_read_rdy = 1'b0; di_reg_datao = 32'h0BAD_F00D; di_transfer_status = 16'h0042;
        sb.push_back('{1'b1, 32'h0BAD_F00D, 16'h0042});
        rp = rd_pulses;
        start(1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0);
        repeat (8) @(posedge ifclk);
        #2 di_read_rdy = 1'b1;
        finish_txn("race", 9, 10);
        check("race terr", 32'(timeout_err), 32'd0);
        check("race rd_pulses", 32'(rd_pulses - rp), 32'd1);

        // Read and write strobes together: read only
        di_read_rdy = 1'b1; di_write_rdy = 1'b1;
        di_reg_datao = 32'h0000_CAFE; di_transfer_status = 16'h0077;
        sb.push_back('{1'b1, 32'h0000_CAFE, 16'h0077});
        rp = rd_pulses; wp = wr_pulses;
        start(1'b1, 1'b1, 32'h0000_0100, 4'h3, 32'h1111_2222);
        @(negedge ifclk);
        check("both req", 32'(di_read_req), 32'd1);
        check("both wr_mode", 32'(di_write_mode), 32'd0);
        @(posedge ifclk); #2;
        finish_txn("both", 2, 3);
        di_write_rdy = 1'b0;
        check("both wr_pulses", 32'(wr_pulses - wp), 32'd0);
        check("both rd_pulses", 32'(rd_pulses - rp), 32'd1);

        // Reset during RD_WAIT aborts without IO_Ready
        di_read_rdy = 1'b0;
        rc = rdy_cnt;
        start(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
        @(posedge ifclk); #2;
        @(negedge ifclk);
        check("abort in_wait", 32'(di_read_mode), 32'd1);
        @(posedge ifclk);
        #2 reset = 1'b1;
        @(posedge ifclk);
        #2 reset = 1'b0;
        @(negedge ifclk);
        check("abort ready", 32'(io.IO_Ready), 32'd0);
        check("abort rd_data", io.IO_Read_Data, 32'd0);
        check("abort status", 32'(mcs_transfer_status), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort rd_mode", 32'(di_read_mode), 32'd0);
        check("abort len", di_len, 32'd1);
        check("abort reg_addr", di_reg_addr, 32'd0);
        repeat (3) @(posedge ifclk);
        #2;
        check("abort no_ready", 32'(rdy_cnt - rc), 32'd0);

        di_read_rdy = 1'b1; di_reg_datao = 32'h8765_4321; di_transfer_status = 16'h0099;
        sb.push_back('{1'b1, 32'h8765_4321, 16'h0099});
        start(1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'h0);
        @(posedge ifclk); #2;
        finish_txn("postrst", 2, 3);

        check("never both pulses", 32'(both_cnt), 32'd0);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
